vga_scan_ctrl: RTL
==================

// Module: vga_scan_ctrl
// PURPOSE
//  Scan sequencer for the VGA output path. Consumes the one-cycle pixel tick derived from the VGA clock generator.
//  Walks horizontal/vertical counters over a full frame and publishes pixel addresses to the frame-buffer reader.
//  Registers returned pixel colour together with hsync/vsync toward the DAC pins.
//  Start/stop is frame-clean: display is enabled or disabled only at frame boundaries.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch; H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch; V_TOTAL = sum = 525
//  CNT_W     10   counter/address width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clkin       in   1      system clock; every register is clocked on its rising edge
//  rst         in   1      asynchronous, active-low reset
//  pix_tick    in   1      one-clkin-cycle pixel enable (25.2 MHz rate)
//  disp_en     in   1      level request to display; sampled only as described below
//  vga_data    in   24     {R,G,B} colour for the current h_addr/v_addr; combinational from the reader
//  h_addr      out  CNT_W  current column, valid only when valid=1, else 0
//  v_addr      out  CNT_W  current row, valid only when valid=1, else 0
//  valid       out  1      counters are inside the active area and state != IDLE
//  frame_start out  1      one-clkin pulse when pixel (0,0) of a frame is issued
//  busy        out  1      state != IDLE
//  hsync       out  1      active-low horizontal sync, registered
//  vsync       out  1      active-low vertical sync, registered
//  vga_r/g/b   out  8 each registered colour; 0 outside the active area
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE, hcnt=vcnt=0, hsync=vsync=1, rgb=0.
//   Also during reset: frame_start=0, busy=0, valid=0, h_addr=v_addr=0.
//  All state changes occur only on clkin edges with pix_tick=1; with pix_tick=0 every register holds.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE:  hcnt/vcnt held at 0; hsync/vsync=1; rgb=0.
//          On pix_tick with disp_en=1 -> RUN; that same tick issues pixel (0,0) and pulses frame_start.
//   RUN:   each tick hcnt++. At H_TOTAL-1, hcnt wraps to 0 and vcnt++.
//          At (H_TOTAL-1, V_TOTAL-1), both wrap to 0 and frame_start pulses.
//          disp_en=0 on a tick -> DRAIN; counting continues without interruption.
//   DRAIN: counts exactly as RUN. disp_en=1 on a tick -> RUN with no counter disturbance.
//          At the frame-end tick with disp_en still 0 -> IDLE with counters at 0; no frame_start pulse.
//  h_addr, v_addr and valid are combinational from hcnt/vcnt/state (same-cycle address to the reader).
//  Output stage (1 pixel latency): on each pix_tick, registers are loaded from the current counters:
//   hsync <= !(H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC)
//   vsync <= !(V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC)
//   rgb   <= valid ? vga_data : 0
//   In IDLE, the output stage loads sync=1 and rgb=0.
//  The colour of pixel (x,y) and its sync levels appear together at the DAC pins one pixel after the address.
//  pix_tick and disp_en changing in the same cycle: disp_en is sampled at that tick edge.
//  Reset mid-frame: immediate return to IDLE values; the next frame starts at (0,0).
// TESTING
//  1. Reset, disp_en=1, tick every 2 clkin -> frame_start at first tick; h_addr 0..639 with valid=1.
//     Then valid=0 for hcnt 640..799; hsync low for exactly 96 ticks starting 657 ticks after line start
//     (hcnt 656 loaded, seen one tick later).
//  2. Full frame -> vsync low for exactly 2*800 ticks starting at line 490 (+1 tick latency).
//     frame_start period exactly 420000 ticks.
//  3. vga_data = {h_addr[7:0], v_addr[7:0], 8'hA5} -> vga_r/g/b equal that value, delayed one tick.
//     0 in blanking.
//  4. Drop disp_en at (100,200) -> busy stays 1 until (799,524).
//     Then IDLE; hsync=vsync=1; rgb=0; no frame_start.
//  5. Drop disp_en at line 10, raise at line 300 -> no gap; the frame completes; frame_start at the next (0,0).
//  6. pix_tick held 0 for 50 clkin mid-line -> all outputs frozen.
//     Assert rst=0 asynchronously between edges -> outputs immediately at reset values.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer. Walks the horizontal and vertical counters across a
// frame, gives the frame-buffer reader a same-cycle pixel address, and
// registers the returned colour together with hsync/vsync toward the DAC.
// The display is started and stopped only on frame boundaries.
//
// valid semantics: valid is a qualifier only, with no ready/back-pressure.
// When valid=1, h_addr/v_addr name a visible pixel and vga_data must carry
// that pixel's colour in the same clkin cycle. When valid=0, h_addr/v_addr
// are forced to 0 and vga_data is ignored.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             pix_tick,
  input  logic             disp_en,
  input  logic [23:0]      vga_data,
  output logic [CNT_W-1:0] h_addr,
  output logic [CNT_W-1:0] v_addr,
  output logic             valid,
  output logic             frame_start,
  output logic             busy,
  output logic             hsync,
  output logic             vsync,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             fs_q, fs_d;
  logic             hsync_q, vsync_q;
  logic [23:0]      rgb_q;

  logic line_end;
  logic frame_end;
  logic in_hsync;
  logic in_vsync;

  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = line_end && (vcnt_q == V_LAST);
  assign in_hsync  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign in_vsync  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

  // Same-cycle address to the reader; zeroed outside the visible area.
  assign busy   = (state_q != IDLE);
  assign valid  = busy && (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
  assign h_addr = valid ? hcnt_q : '0;
  assign v_addr = valid ? vcnt_q : '0;

  // State, counter and frame_start registers.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      // Reloaded every clkin, so the pulse lasts exactly one clkin cycle.
      fs_q    <= fs_d;
    end
  end

  // Next state and counters; nothing moves without a pixel tick.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fs_d    = 1'b0;
    if (pix_tick) begin
      case (state_q)
        IDLE: begin
          hcnt_d = '0;
          vcnt_d = '0;
          // The starting tick makes (0,0) the current pixel.
          if (disp_en) begin
            state_d = RUN;
            fs_d    = 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (line_end) begin
            hcnt_d = '0;
            vcnt_d = frame_end ? '0 : vcnt_q + CNT_W'(1);
          end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
          fs_d = frame_end;
          if (disp_en) begin
            state_d = RUN;
          end else if ((state_q == DRAIN) && frame_end) begin
            // Frame finished with display off: park, no new frame.
            state_d = IDLE;
            fs_d    = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      endcase
    end
  end

  // Output stage: one pixel behind the address, syncs aligned with colour.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else if (pix_tick) begin
      if (state_q == IDLE) begin
        hsync_q <= 1'b1;
        vsync_q <= 1'b1;
        rgb_q   <= '0;
      end else begin
        hsync_q <= !in_hsync;
        vsync_q <= !in_vsync;
        rgb_q   <= valid ? vga_data : 24'h0;
      end
    end
  end

  assign frame_start = fs_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
